// File: rtl/pimt_pkg.sv
// Shared definitions for the pimt vector multiplier: default widths,
// the round-half-up/saturate helper and the packed-lane offset helper.
package pimt_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 16;

    // Widest lane the rounding helper supports; the product is evaluated at
    // twice this width so the rounding add can never overflow.
    localparam int SR_MAX_W = 64;
    localparam int SR_PW    = 2 * SR_MAX_W;
    localparam logic signed [SR_PW-1:0] SR_ONE = {{(SR_PW-1){1'b0}}, 1'b1};

    // Round a full signed product half-up by frac_w bits and clamp it to a
    // data_w-bit signed range. Returns {sat, result}; the caller keeps the
    // low data_w bits of result.
    function automatic logic [SR_MAX_W:0] sat_round(
        input logic signed [SR_PW-1:0] p,
        input int                      data_w,
        input int                      frac_w
    );
        logic signed [SR_PW-1:0] half;
        logic signed [SR_PW-1:0] r;
        logic signed [SR_PW-1:0] max_pos;
        logic signed [SR_PW-1:0] min_neg;
        half    = SR_ONE <<< (frac_w - 1);
        max_pos = (SR_ONE <<< (data_w - 1)) - SR_ONE;
        min_neg = -max_pos - SR_ONE;
        r       = (p + half) >>> frac_w;
        if (r > max_pos) begin
            sat_round = {1'b1, max_pos[SR_MAX_W-1:0]};
        end else if (r < min_neg) begin
            sat_round = {1'b1, min_neg[SR_MAX_W-1:0]};
        end else begin
            sat_round = {1'b0, r[SR_MAX_W-1:0]};
        end
    endfunction

    // Bit offset of lane `lane` inside a packed multi-lane bus.
    function automatic int LANE_SEL(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pimt_mul_lane.sv
// Single-lane fixed-latency multiply / round / saturate pipe. Carries no
// valid; the top aligns its own valid shift register with this latency.
module pimt_mul_lane
    import pimt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int LAT    = 3
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic        [DATA_W-1:0] result,
    output logic                     sat
);

    localparam int PW = SR_PW;

    logic signed [2*DATA_W-1:0] prod_p0;
    logic        [SR_MAX_W:0]   rounded;
    logic        [DATA_W:0]     res_p1 [LAT-1];

    assign rounded = sat_round(PW'(prod_p0), DATA_W, FRAC_W);

    generate
        if (DATA_W < SR_MAX_W) begin : g_unused_hi
            logic unused_rounded_hi;
            assign unused_rounded_hi = ^rounded[SR_MAX_W-1:DATA_W];
        end
    endgenerate

    // Stage 0 registers the full product; stage 1 registers the rounded,
    // clamped value; the remaining stages only delay it to total LAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p0 <= '0;
            for (int i = 0; i < LAT - 1; i++) begin
                res_p1[i] <= '0;
            end
        end else begin
            prod_p0   <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
            res_p1[0] <= {rounded[SR_MAX_W], rounded[DATA_W-1:0]};
            for (int i = 1; i < LAT - 1; i++) begin
                res_p1[i] <= res_p1[i-1];
            end
        end
    end

    assign {sat, result} = res_p1[LAT-2];

endmodule

// File: rtl/pimt_vec_mul.sv
// LANES-wide signed fixed-point multiplier with a fixed-latency pipe feeding
// a first-word-fall-through output FIFO. Input ready is granted from credits
// (buffered + in-flight beats) so the FIFO can never overflow.
module pimt_vec_mul
    import pimt_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAC_W     = DEF_FRAC_W,
    parameter int LANES      = 4,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 8
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alphamulk_vld,
    output logic                      alphamulk_rdy,
    input  logic [LANES*DATA_W-1:0]   alpha_mul_k,
    input  logic [LANES*DATA_W-1:0]   pi_m_i,
    output logic [LANES*DATA_W-1:0]   pimt_result,
    output logic [LANES-1:0]          pimt_sat,
    output logic                      pimt_result_vld,
    input  logic                      pimt_result_rdy,
    output logic [15:0]               sat_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + LAT) + 1;
    localparam int EW = LANES * DATA_W + LANES;

    logic                    accept;
    logic [LAT-1:0]          vld_p;
    logic [LANES*DATA_W-1:0] res_lanes;
    logic [LANES-1:0]        sat_lanes;
    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             fifo_count;
    logic [CW-1:0]           inflight;
    logic                    wr_en;
    logic                    rd_en;

    assign accept = alphamulk_vld & alphamulk_rdy;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            pimt_mul_lane #(
                .DATA_W (DATA_W),
                .FRAC_W (FRAC_W),
                .LAT    (LAT)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .a      (alpha_mul_k[LANE_SEL(g, DATA_W) +: DATA_W]),
                .b      (pi_m_i[LANE_SEL(g, DATA_W) +: DATA_W]),
                .result (res_lanes[LANE_SEL(g, DATA_W) +: DATA_W]),
                .sat    (sat_lanes[g])
            );
        end
    endgenerate

    // Valid shift register running alongside the lane pipes; never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[LAT-2:0], accept};
        end
    end

    // Count beats still travelling through the pipe for the credit check.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(vld_p[i]);
        end
    end

    assign alphamulk_rdy   = (CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH);
    assign wr_en           = vld_p[LAT-1];
    assign pimt_result_vld = (fifo_count != '0);
    assign rd_en           = pimt_result_vld & pimt_result_rdy;
    assign {pimt_sat, pimt_result} = mem[rd_ptr];

    // FIFO storage, pointers and occupancy; credits make a write into a
    // full FIFO impossible, so no full guard is needed on the write side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {sat_lanes, res_lanes};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Count written beats with any saturated lane, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (wr_en && (|sat_lanes) && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pimt_vec_mul.sv
// Randomised self-checking bench for pimt_vec_mul with an in-order
// behavioural reference (queue of expected beats).
module tb_pimt_vec_mul;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alphamulk_vld;
    logic         alphamulk_rdy;
    logic [127:0] alpha_mul_k;
    logic [127:0] pi_m_i;
    logic [127:0] pimt_result;
    logic [3:0]   pimt_sat;
    logic         pimt_result_vld;
    logic         pimt_result_rdy;
    logic [15:0]  sat_cnt;

    pimt_vec_mul #(
        .DATA_W(32), .FRAC_W(16), .LANES(4), .LAT(3), .FIFO_DEPTH(8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alphamulk_vld   (alphamulk_vld),
        .alphamulk_rdy   (alphamulk_rdy),
        .alpha_mul_k     (alpha_mul_k),
        .pi_m_i          (pi_m_i),
        .pimt_result     (pimt_result),
        .pimt_sat        (pimt_sat),
        .pimt_result_vld (pimt_result_vld),
        .pimt_result_rdy (pimt_result_rdy),
        .sat_cnt         (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] res;
        logic [3:0]   sat;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   tests       = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   outstanding = 0;
    int   acc_total   = 0;
    int   sat_beats   = 0;
    bit   lat_check   = 0;
    exp_t e_new;
    exp_t e_head;
    logic [32:0] lr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Fixed-point reference: exact product, add half an LSB, arithmetic shift, clamp.
    function automatic logic [32:0] ref_lane(input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint r;
        p = longint'($signed(a)) * longint'($signed(b));
        r = (p + 64'sd32768) >>> 16;
        if (r > 64'sd2147483647)  return {1'b1, 32'h7FFFFFFF};
        if (r < -64'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, r[31:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 2))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 32'h0003FFFF) - 32'h00020000;
            default: v = 32'h7FFF0000 ^ $urandom_range(0, 32'h0001FFFF);
        endcase
        return v;
    endfunction

    task automatic drive_rand();
        for (int l = 0; l < 4; l++) begin
            alpha_mul_k[l*32 +: 32] = rand_op();
            pi_m_i[l*32 +: 32]      = rand_op();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(nm, 128'(q.size() == 0), 128'd1);
    endtask

    // Reference model and output comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            outstanding = 0;
            sat_beats   = 0;
        end else begin
            check("in_rdy", 128'(alphamulk_rdy), 128'(outstanding < 8));
            if (pimt_result_vld) begin
                if (q.size() == 0) begin
                    check("unexpected_vld", 128'(pimt_result_vld), 128'd0);
                end else begin
                    e_head = q[0];
                    check("result", pimt_result, e_head.res);
                    check("sat", 128'(pimt_sat), 128'(e_head.sat));
                    if (pimt_result_rdy) begin
                        if (lat_check) check("latency", 128'(cyc - e_head.cyc), 128'd4);
                        void'(q.pop_front());
                        outstanding--;
                    end
                end
            end
            if (alphamulk_vld && alphamulk_rdy) begin
                for (int l = 0; l < 4; l++) begin
                    lr = ref_lane(alpha_mul_k[l*32 +: 32], pi_m_i[l*32 +: 32]);
                    e_new.res[l*32 +: 32] = lr[31:0];
                    e_new.sat[l]          = lr[32];
                end
                e_new.cyc = cyc;
                q.push_back(e_new);
                outstanding++;
                acc_total++;
                if (e_new.sat != 4'b0 && sat_beats < 16'hFFFF) sat_beats++;
            end
        end
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        int acc0;
        int vcnt;
        rst_n           = 1'b0;
        alphamulk_vld   = 1'b0;
        pimt_result_rdy = 1'b1;
        alpha_mul_k     = '0;
        pi_m_i          = '0;

        // Pin the reference model to hand-computed values.
        check("pin_basic",  128'(ref_lane(32'h00018000, 32'h00020000)), 128'({1'b0, 32'h00030000}));
        check("pin_rnd_up", 128'(ref_lane(32'h00000001, 32'h00008000)), 128'({1'b0, 32'h00000001}));
        check("pin_rnd_ng", 128'(ref_lane(32'hFFFFFFFF, 32'h00008000)), 128'({1'b0, 32'h00000000}));
        check("pin_sat_hi", 128'(ref_lane(32'h7FFF0000, 32'h00020000)), 128'({1'b1, 32'h7FFFFFFF}));
        check("pin_sat_lo", 128'(ref_lane(32'h80000000, 32'h00020000)), 128'({1'b1, 32'h80000000}));

        repeat (2) tick();
        check("rst_vld",     128'(pimt_result_vld), 128'd0);
        check("rst_result",  pimt_result, 128'd0);
        check("rst_sat",     128'(pimt_sat), 128'd0);
        check("rst_sat_cnt", 128'(sat_cnt), 128'd0);
        check("rst_in_rdy",  128'(alphamulk_rdy), 128'd1);
        #2 rst_n = 1'b1;
        tick();

        // Basic multiply and rounding in one beat; check first-result latency.
        lat_check     = 1;
        alpha_mul_k   = {32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00018000};
        pi_m_i        = {32'h00007FFF, 32'h00008000, 32'h00008000, 32'h00020000};
        alphamulk_vld = 1'b1;
        tick();
        alphamulk_vld = 1'b0;
        check("lat_c1", 128'(pimt_result_vld), 128'd0);
        tick();
        check("lat_c2", 128'(pimt_result_vld), 128'd0);
        tick();
        check("lat_c3", 128'(pimt_result_vld), 128'd0);
        tick();
        check("lat_c4", 128'(pimt_result_vld), 128'd1);
        check("basic_result", pimt_result, {32'h0, 32'h0, 32'h1, 32'h00030000});
        check("basic_sat", 128'(pimt_sat), 128'd0);
        drain("drain_basic");

        // Saturation beat.
        alpha_mul_k   = {32'h0, 32'h0, 32'h80000000, 32'h7FFF0000};
        pi_m_i        = {32'h0, 32'h0, 32'h00020000, 32'h00020000};
        alphamulk_vld = 1'b1;
        tick();
        alphamulk_vld = 1'b0;
        repeat (3) tick();
        check("sat_result", pimt_result, {32'h0, 32'h0, 32'h80000000, 32'h7FFFFFFF});
        check("sat_flags", 128'(pimt_sat), 128'b0011);
        drain("drain_sat");
        check("sat_cnt_one", 128'(sat_cnt), 128'd1);
        lat_check = 0;

        // Backpressure: downstream stalled while input stays valid.
        pimt_result_rdy = 1'b0;
        acc0            = acc_total;
        alphamulk_vld   = 1'b1;
        repeat (20) begin
            drive_rand();
            tick();
        end
        check("bp_accepted", 128'(acc_total - acc0), 128'd8);
        check("bp_in_rdy", 128'(alphamulk_rdy), 128'd0);
        pimt_result_rdy = 1'b1;
        vcnt = 0;
        repeat (40) begin
            drive_rand();
            tick();
            if (pimt_result_vld) vcnt++;
        end
        check("bp_no_gaps", 128'(vcnt), 128'd40);
        alphamulk_vld = 1'b0;
        drain("drain_bp");

        // Back-to-back stream at full rate.
        lat_check     = 1;
        acc0          = acc_total;
        alphamulk_vld = 1'b1;
        repeat (100) begin
            drive_rand();
            tick();
        end
        alphamulk_vld = 1'b0;
        check("stream_accepted", 128'(acc_total - acc0), 128'd100);
        drain("drain_stream");
        lat_check = 0;

        // Random valid/ready traffic.
        repeat (300) begin
            drive_rand();
            alphamulk_vld   = 1'($urandom_range(0, 1));
            pimt_result_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        alphamulk_vld   = 1'b0;
        pimt_result_rdy = 1'b1;
        drain("drain_rand");
        check("rand_sat_cnt", 128'(sat_cnt), 128'(sat_beats));

        // Reset with 3 beats in the pipe and 5 in the FIFO.
        pimt_result_rdy = 1'b0;
        alpha_mul_k     = {4{32'h7FFF0000}};
        pi_m_i          = {4{32'h7FFF0000}};
        alphamulk_vld   = 1'b1;
        repeat (8) tick();
        alphamulk_vld = 1'b0;
        check("pre_rst_sat_cnt", 128'(sat_cnt), 128'(sat_beats + 5 - 8));
        check("pre_rst_vld", 128'(pimt_result_vld), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld",     128'(pimt_result_vld), 128'd0);
        check("mid_rst_result",  pimt_result, 128'd0);
        check("mid_rst_sat",     128'(pimt_sat), 128'd0);
        check("mid_rst_sat_cnt", 128'(sat_cnt), 128'd0);
        check("mid_rst_in_rdy",  128'(alphamulk_rdy), 128'd1);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        pimt_result_rdy = 1'b1;
        repeat (10) begin
            tick();
            check("post_rst_quiet", 128'(pimt_result_vld), 128'd0);
        end
        drive_rand();
        alphamulk_vld = 1'b1;
        tick();
        alphamulk_vld = 1'b0;
        drain("drain_post_rst");
        check("post_rst_sat_cnt", 128'(sat_cnt), 128'(sat_beats));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
